stack_param: RTL and testbench
==============================

# stack_param

Parametrised LIFO register stack for the CPU: the next-generation replacement for the fixed 32x128 register-backup stack. It is configurable in data width and depth and reports occupancy. It detects and flags overflow and underflow, and can optionally raise an interrupt on those errors. It sits beside the register file and is driven by the push/pop micro-ops, plus the pipeline's flush (`clear`) and stall (`hold`) controls.

## Interface
- `DATA_W`, default 32: entry width in bits.
- `DEPTH`, default 128: number of entries; must be a power of two, ≥ 2. `PTR_W = $clog2(DEPTH)` is a derived localparam.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears pointer, output and flags.
- `d` input DATA_W: data to push.
- `q` output DATA_W: registered result of the last accepted pop.
- `push` input 1: push request.
- `pop` input 1: pop request.
- `clear` input 1: flush. Discards a pending pop and forces `q` to 0.
- `hold` input 1: stall. Discards a pending pop and keeps `q` unchanged.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `count` output PTR_W+1: number of valid entries, 0..DEPTH.
- `err_ovf` output 1: sticky overflow flag.
- `err_unf` output 1: sticky underflow flag.
- `err_ack` input 1: clears both sticky flags.
- `irq` output 1: one-cycle error interrupt pulse.

## Operation
- State:
  - pointer `ptr` (PTR_W+1 bits, equal to `count`);
  - storage array of DEPTH x DATA_W (not reset);
  - `q` register;
  - two error flags.
- Pop path priority per cycle: `clear` > `hold` > `pop`. `clear` and `hold` act only on the pop path; `push` is never gated by them.
- Effective pop = `pop & ~clear & ~hold`.
- Push alone, not full: `mem[ptr] <= d`, `ptr <= ptr+1`.
- Push alone, full: write and pointer change are suppressed; overflow event.
- Effective pop alone, not empty: `q <= mem[ptr-1]`, `ptr <= ptr-1`.
- Effective pop alone, empty: `q <= 0`, `ptr` unchanged; underflow event.
- Push + effective pop, not empty (including full): swap.
  - `q <= mem[ptr-1]` (old top).
  - `mem[ptr-1] <= d`.
  - `ptr` unchanged; no error.
- Push + effective pop, empty: underflow event, `q <= 0`; the push executes normally (`count` becomes 1).
- `pop & clear`: `q <= 0`, `ptr` unchanged, no error.
- `pop & hold` (no `clear`): `q` and `ptr` unchanged, no error.
- `clear` without `pop` still forces `q <= 0`.
- Error flags are set on their event and cleared by `err_ack`. If an event and `err_ack` occur in the same cycle, the set wins.
- `ptr` is PTR_W+1 bits wide, so it never wraps. Memory addressing uses `ptr[PTR_W-1:0]`.

## Timing
- Reset values: `q`=0, `count`=0, `empty`=1, `full`=0, `err_ovf`=0, `err_unf`=0, `irq`=0.
- Reset is asynchronous, so it can occur mid-operation. Any in-flight push or pop is lost and memory contents are retained but treated as invalid.
- Pop latency is 1 cycle: a pop accepted at edge N drives `q` valid after edge N, and `q` holds that value until the next accepted pop, a `clear`, or reset.
- `count`, `full` and `empty` update on the same edge as `ptr` and are registered or derived from the registered `ptr` (no combinational path from `push`/`pop`).
- A push at edge N followed by a pop at edge N+1 returns the pushed data (no read-after-write hazard).
- Error flags are set on the edge after the offending request is sampled.

## Configuration
- `STACK_ERR_IRQ_EN` defined:
  - `irq` pulses high for exactly one cycle on every overflow or underflow event, including repeat events while the flag is already set.
  - If both events occur in one cycle, a single pulse is produced.
- `STACK_ERR_IRQ_EN` undefined:
  - `irq` is tied to 0.
  - `err_ovf` and `err_unf` still operate.
  - Stack behaviour is otherwise identical.

## Test plan
- Reset check: assert `reset` asynchronously between edges. Outputs go to their reset values immediately (`count`=0, `empty`=1, `q`=0, flags 0); deassert and verify no spurious events.
- LIFO order: push 0x11, 0x22, 0x33, then pop three times. `q` reads 0x33, 0x22, 0x11 one cycle after each pop; `count` goes 3→0 and `empty`=1 at the end.
- Full and overflow (`DEPTH`=128):
  - push 128 values; expect `full`=1 and `count`=128;
  - push 0xDEAD; expect `count` stays 128, `err_ovf`=1, and one `irq` pulse (macro on);
  - pop; expect the 128th value, not 0xDEAD;
  - assert `err_ack`; expect `err_ovf`=0.
- Underflow: on an empty stack, pop. Expect `q`=0, `count`=0, `err_unf`=1, `irq` pulse. Then push 0x5 together with pop: expect `err_unf` stays set and `count`=1.
- Swap: push 0xA then 0xB; push 0xC together with pop. Expect `q`=0xB and `count`=2; then two pops return 0xC and 0xA.
- Flush/stall: push 0x7; pop with `hold` → `q` unchanged, `count`=1; pop with `clear` → `q`=0, `count`=1; pop alone → `q`=0x7, `count`=0.

Source files
------------

// File: rtl/stack_param.sv
// Parametrised LIFO register stack with occupancy and sticky error flags.
// Optional error interrupt pulse enabled by defining STACK_ERR_IRQ_EN.
module stack_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        d,
    output logic [DATA_W-1:0]        q,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic                     hold,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_ovf,
    output logic                     err_unf,
    input  logic                     err_ack,
    output logic                     irq
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;

    logic              pop_eff;
    logic              full_w, empty_w;
    logic              we;
    logic [PTR_W-1:0]  waddr;
    logic [PTR_W-1:0]  top_idx;
    logic              ovf_ev, unf_ev;

    assign full_w  = (ptr_q == DEPTH[PTR_W:0]);
    assign empty_w = (ptr_q == '0);
    // Wraps to DEPTH-1 when full, which is exactly the top entry.
    assign top_idx = ptr_q[PTR_W-1:0] - 1'b1;

    always_comb begin
        pop_eff = pop & ~clear & ~hold;
        ptr_d   = ptr_q;
        q_d     = q_q;
        we      = 1'b0;
        waddr   = ptr_q[PTR_W-1:0];
        ovf_ev  = 1'b0;
        unf_ev  = 1'b0;

        if (clear) begin
            q_d = '0;
        end

        case ({push, pop_eff})
            2'b10: begin
                if (!full_w) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                end else begin
                    ovf_ev = 1'b1;
                end
            end
            2'b01: begin
                if (!empty_w) begin
                    q_d   = mem[top_idx];
                    ptr_d = ptr_q - 1'b1;
                end else begin
                    q_d    = '0;
                    unf_ev = 1'b1;
                end
            end
            2'b11: begin
                if (!empty_w) begin
                    q_d   = mem[top_idx];
                    we    = 1'b1;
                    waddr = top_idx;
                end else begin
                    q_d    = '0;
                    unf_ev = 1'b1;
                    we     = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                end
            end
            default: ;
        endcase

        // An event in the same cycle as the acknowledge keeps the flag set.
        err_ovf_d = ovf_ev | (err_ovf_q & ~err_ack);
        err_unf_d = unf_ev | (err_unf_q & ~err_ack);
    end

    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[waddr] <= d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            q_q       <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            q_q       <= q_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

`ifdef STACK_ERR_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = ovf_ev | unf_ev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign q       = q_q;
    assign count   = ptr_q;
    assign full    = full_w;
    assign empty   = empty_w;
    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;

endmodule

// File: tb/tb_stack_param.sv
// Randomized bench for stack_param against a queue-based LIFO model.
// Checks directed scenarios first, then a long random mix including resets.
module tb_stack_param;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;
    localparam int PTR_W  = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] d = '0;
    logic [DATA_W-1:0] q;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              clear = 1'b0;
    logic              hold = 1'b0;
    logic              full;
    logic              empty;
    logic [PTR_W:0]    count;
    logic              err_ovf;
    logic              err_unf;
    logic              err_ack = 1'b0;
    logic              irq;

    int total = 0;
    int bad = 0;

    logic [DATA_W-1:0] stk[$];
    logic [DATA_W-1:0] mq;
    bit                mo, mu, mirq;

    stack_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .d(d), .q(q),
        .push(push), .pop(pop), .clear(clear), .hold(hold),
        .full(full), .empty(empty), .count(count),
        .err_ovf(err_ovf), .err_unf(err_unf),
        .err_ack(err_ack), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"}, 64'(q), 64'(mq));
        check({tag, ".count"}, 64'(count), 64'(stk.size()));
        check({tag, ".full"}, 64'(full), 64'(stk.size() == DEPTH));
        check({tag, ".empty"}, 64'(empty), 64'(stk.size() == 0));
        check({tag, ".ovf"}, 64'(err_ovf), 64'(mo));
        check({tag, ".unf"}, 64'(err_unf), 64'(mu));
        check({tag, ".irq"}, 64'(irq), 64'(mirq));
    endtask

    task automatic model_reset();
        stk.delete();
        mq   = '0;
        mo   = 1'b0;
        mu   = 1'b0;
        mirq = 1'b0;
    endtask

    task automatic model_edge(input bit pu, po, cl, ho, ak,
                              input logic [DATA_W-1:0] dv);
        bit pe, ov, un;
        pe = po && !cl && !ho;
        ov = 1'b0;
        un = 1'b0;
        if (cl) mq = '0;
        if (pu && !pe) begin
            if (stk.size() < DEPTH) stk.push_back(dv);
            else ov = 1'b1;
        end else if (pe && !pu) begin
            if (stk.size() > 0) mq = stk.pop_back();
            else begin mq = '0; un = 1'b1; end
        end else if (pu && pe) begin
            if (stk.size() > 0) begin
                mq = stk[stk.size()-1];
                stk[stk.size()-1] = dv;
            end else begin
                mq = '0;
                un = 1'b1;
                stk.push_back(dv);
            end
        end
        mo = ov || (mo && !ak);
        mu = un || (mu && !ak);
`ifdef STACK_ERR_IRQ_EN
        mirq = ov || un;
`else
        mirq = 1'b0;
`endif
    endtask

    task automatic step(input string tag, input bit pu, po, cl, ho, ak,
                        input logic [DATA_W-1:0] dv);
        push    = pu;
        pop     = po;
        clear   = cl;
        hold    = ho;
        err_ack = ak;
        d       = dv;
        @(posedge clk);
        model_edge(pu, po, cl, ho, ak, dv);
        #1;
        check_all(tag);
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        hold    = 1'b0;
        err_ack = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset = 1'b0;
        step({tag, ".idle"}, 0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_all("por");
        reset = 1'b0;
        step("por.idle", 0, 0, 0, 0, 0, '0);

        step("lifo.p1", 1, 0, 0, 0, 0, 32'h11);
        step("lifo.p2", 1, 0, 0, 0, 0, 32'h22);
        step("lifo.p3", 1, 0, 0, 0, 0, 32'h33);
        step("lifo.o1", 0, 1, 0, 0, 0, '0);
        check("lifo.q33", 64'(q), 64'h33);
        step("lifo.o2", 0, 1, 0, 0, 0, '0);
        check("lifo.q22", 64'(q), 64'h22);
        step("lifo.o3", 0, 1, 0, 0, 0, '0);
        check("lifo.q11", 64'(q), 64'h11);

        for (int i = 0; i < DEPTH; i++)
            step("full.fill", 1, 0, 0, 0, 0, 32'(1000 + i));
        check("full.flag", 64'(full), 64'd1);
        step("full.ovf", 1, 0, 0, 0, 0, 32'hDEAD);
        check("full.ovf_set", 64'(err_ovf), 64'd1);
        step("full.pop", 0, 1, 0, 0, 0, '0);
        check("full.q_last", 64'(q), 64'(1000 + DEPTH - 1));
        step("full.ack", 0, 0, 0, 0, 1, '0);
        check("full.ack_clr", 64'(err_ovf), 64'd0);
        step("full.swap_top", 1, 1, 0, 0, 0, 32'hBEEF);
        step("full.refill", 1, 0, 0, 0, 0, 32'h1);
        step("full.swap_full", 1, 1, 0, 0, 0, 32'h2);
        check("full.swap_q", 64'(q), 64'h1);
        step("full.ovf_ack", 1, 0, 0, 0, 1, 32'h3);
        check("full.set_wins", 64'(err_ovf), 64'd1);

        async_reset("rst.mid");

        step("unf.pop", 0, 1, 0, 0, 0, '0);
        check("unf.flag", 64'(err_unf), 64'd1);
        step("unf.pushpop", 1, 1, 0, 0, 0, 32'h5);
        check("unf.count1", 64'(count), 64'd1);
        step("unf.ack", 0, 0, 0, 0, 1, '0);
        step("unf.drain", 0, 1, 0, 0, 0, '0);

        step("swap.a", 1, 0, 0, 0, 0, 32'hA);
        step("swap.b", 1, 0, 0, 0, 0, 32'hB);
        step("swap.c", 1, 1, 0, 0, 0, 32'hC);
        check("swap.qB", 64'(q), 64'hB);
        step("swap.o1", 0, 1, 0, 0, 0, '0);
        check("swap.qC", 64'(q), 64'hC);
        step("swap.o2", 0, 1, 0, 0, 0, '0);
        check("swap.qA", 64'(q), 64'hA);

        step("fl.push", 1, 0, 0, 0, 0, 32'h7);
        step("fl.hold", 0, 1, 0, 1, 0, '0);
        check("fl.hold_q", 64'(q), 64'hA);
        step("fl.clear", 0, 1, 1, 0, 0, '0);
        check("fl.clear_q", 64'(q), 64'h0);
        step("fl.clear_np", 1, 0, 1, 1, 0, 32'h9);
        step("fl.pop", 0, 1, 0, 0, 0, '0);
        step("fl.pop2", 0, 1, 0, 0, 0, '0);
        check("fl.q7", 64'(q), 64'h7);

        async_reset("rst.b");

        for (int i = 0; i < 4000; i++) begin
            int pp;
            bit pu, po, cl, ho, ak;
            pp = ((i / 300) % 2 == 0) ? 75 : 30;
            pu = ($urandom_range(0, 99) < pp);
            po = ($urandom_range(0, 99) < 100 - pp);
            cl = ($urandom_range(0, 99) < 8);
            ho = ($urandom_range(0, 99) < 8);
            ak = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 999) < 4) async_reset("rnd.rst");
            else step("rnd", pu, po, cl, ho, ak, 32'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
